// File: rtl/fsmc_pkg.sv
// Shared widths and FSM encoding for the FSMC-to-memory bridge.
package fsmc_pkg;
   localparam int ADDR_W_DEF      = 16;
   localparam int DATA_W_DEF      = 16;
   localparam int SYNC_STAGES_DEF = 2;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_REQ   = 3'd1,
      RD_REQ   = 3'd2,
      RD_WAIT  = 3'd3,
      RD_DRIVE = 3'd4
   } state_e;
endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an active-low strobe (resets to 1) with
// single-cycle rise/fall pulses on the synchronized level.
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dly_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '1;
         dly_q  <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
         dly_q  <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync_o = sync_q[SYNC_STAGES-1];
   assign rise_o = sync_q[SYNC_STAGES-1] & ~dly_q;
   assign fall_o = ~sync_q[SYNC_STAGES-1] & dly_q;
endmodule

// File: rtl/fsmc_bridge.sv
// FSMC asynchronous SRAM-bus responder: posts completed write strobes and
// turns read strobes into memory reads whose data is driven back on the bus.
module fsmc_bridge
   import fsmc_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] fsmc_a_i,
   inout  wire  [DATA_W-1:0] fsmc_d_io,
   input  logic              fsmc_ne1_i,
   input  logic              fsmc_nwe_i,
   input  logic              fsmc_noe_i,
   input  logic              fsmc_nbl1_i,
   input  logic              fsmc_nbl0_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [1:0]        mem_be_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_rvalid_i,
   output logic              busy_o,
   output logic              err_overflow_o,
   output logic              fsmc_d_oe_o
);
   logic ne1_s, ne1_rise, ne1_fall;
   logic nwe_s, nwe_rise, nwe_fall;
   logic noe_s, noe_rise, noe_fall;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ne1 (
      .clk_i(clk_i), .rst_i(rst_i), .async_i(fsmc_ne1_i),
      .sync_o(ne1_s), .rise_o(ne1_rise), .fall_o(ne1_fall));
   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_nwe (
      .clk_i(clk_i), .rst_i(rst_i), .async_i(fsmc_nwe_i),
      .sync_o(nwe_s), .rise_o(nwe_rise), .fall_o(nwe_fall));
   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_noe (
      .clk_i(clk_i), .rst_i(rst_i), .async_i(fsmc_noe_i),
      .sync_o(noe_s), .rise_o(noe_rise), .fall_o(noe_fall));

   // "Was low last cycle" == low now and did not just fall, or just rose.
   logic ne1_was_low, nwe_was_low, wr_done, rd_act, rd_start, rd_end;
   assign ne1_was_low = (~ne1_s & ~ne1_fall) | ne1_rise;
   assign nwe_was_low = (~nwe_s & ~nwe_fall) | nwe_rise;
   assign wr_done     = (nwe_rise & ne1_was_low) | (ne1_rise & nwe_was_low);
   assign rd_act      = ~ne1_s & ~noe_s;
   assign rd_start    = (ne1_fall & ~noe_s) | (noe_fall & ~ne1_s);
   assign rd_end      = ne1_rise | noe_rise | (ne1_s | noe_s);

   logic [ADDR_W-1:0] cap_addr_q;
   logic [DATA_W-1:0] cap_data_q;
   logic [1:0]        cap_be_q;

   // Raw pins are sampled; the synchronizer delay lets them settle first.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cap_addr_q <= '0;
         cap_data_q <= '0;
         cap_be_q   <= '0;
      end else if (~ne1_s & ~nwe_s) begin
         cap_addr_q <= fsmc_a_i;
         cap_data_q <= fsmc_d_io;
         cap_be_q   <= ~{fsmc_nbl1_i, fsmc_nbl0_i};
      end
   end

   state_e            state_q, state_d;
   logic              we_q, we_d, pend_q, pend_d, err_q, err_d;
   logic [ADDR_W-1:0] addr_q, addr_d, rd_addr_q, rd_addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, rd_hold_q, rd_hold_d;
   logic [1:0]        be_q, be_d, rd_be_q, rd_be_d;

   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      pend_d    = pend_q;
      rd_addr_d = rd_addr_q;
      rd_be_d   = rd_be_q;
      rd_hold_d = rd_hold_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (wr_done) begin
               state_d = WR_REQ;
               we_d    = 1'b1;
               addr_d  = cap_addr_q;
               wdata_d = cap_data_q;
               be_d    = cap_be_q;
               if (rd_start) begin
                  pend_d    = 1'b1;
                  rd_addr_d = fsmc_a_i;
                  rd_be_d   = ~{fsmc_nbl1_i, fsmc_nbl0_i};
               end
            end else if (rd_start) begin
               state_d = RD_REQ;
               we_d    = 1'b0;
               addr_d  = fsmc_a_i;
               be_d    = ~{fsmc_nbl1_i, fsmc_nbl0_i};
            end
         end
         WR_REQ: begin
            if (wr_done) err_d = 1'b1;
            if (rd_start) begin
               pend_d    = 1'b1;
               rd_addr_d = fsmc_a_i;
               rd_be_d   = ~{fsmc_nbl1_i, fsmc_nbl0_i};
            end
            if (mem_ack_i) begin
               if (pend_q || rd_start) begin
                  state_d = RD_REQ;
                  we_d    = 1'b0;
                  addr_d  = rd_start ? fsmc_a_i : rd_addr_q;
                  be_d    = rd_start ? ~{fsmc_nbl1_i, fsmc_nbl0_i} : rd_be_q;
                  pend_d  = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         RD_REQ: if (mem_ack_i) state_d = RD_WAIT;
         RD_WAIT: begin
            if (mem_rvalid_i) begin
               rd_hold_d = mem_rdata_i;
               state_d   = rd_act ? RD_DRIVE : IDLE;
            end
         end
         RD_DRIVE: if (rd_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         pend_q    <= 1'b0;
         rd_addr_q <= '0;
         rd_be_q   <= '0;
         rd_hold_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         pend_q    <= pend_d;
         rd_addr_q <= rd_addr_d;
         rd_be_q   <= rd_be_d;
         rd_hold_q <= rd_hold_d;
         err_q     <= err_d;
      end
   end

   assign mem_req_o      = (state_q == WR_REQ) || (state_q == RD_REQ);
   assign mem_we_o       = we_q;
   assign mem_addr_o     = addr_q;
   assign mem_wdata_o    = wdata_q;
   assign mem_be_o       = be_q;
   assign busy_o         = (state_q != IDLE);
   assign err_overflow_o = err_q;
   assign fsmc_d_oe_o    = (state_q == RD_DRIVE);
   assign fsmc_d_io      = fsmc_d_oe_o ? rd_hold_q : 'z;
endmodule

// File: tb/tb_fsmc_bridge.sv
// Randomized self-checking bench for fsmc_bridge: FSMC bus driver, memory
// responder, and a transaction-level reference (expected requests + memory).
module tb_fsmc_bridge;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] fsmc_a;
   wire  [15:0] fsmc_d;
   logic [15:0] tb_d;
   logic        tb_d_oe;
   logic        ne1, nwe, noe, nbl1, nbl0;
   logic        mem_req, mem_we, mem_ack, mem_rvalid, busy, err_ovf, d_oe;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  mem_be;

   always #5 clk = ~clk;
   assign fsmc_d = tb_d_oe ? tb_d : 'z;

   fsmc_bridge dut (
      .clk_i(clk), .rst_i(rst), .fsmc_a_i(fsmc_a), .fsmc_d_io(fsmc_d),
      .fsmc_ne1_i(ne1), .fsmc_nwe_i(nwe), .fsmc_noe_i(noe),
      .fsmc_nbl1_i(nbl1), .fsmc_nbl0_i(nbl0),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_ack_i(mem_ack),
      .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid),
      .busy_o(busy), .err_overflow_o(err_ovf), .fsmc_d_oe_o(d_oe));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [1:0]  be;
   } req_t;

   req_t        exp_q[$];
   logic [15:0] ref_mem [logic [15:0]];
   logic [15:0] env_mem [logic [15:0]];

   function automatic logic [15:0] lane_mask(input logic [1:0] be);
      return {{8{be[1]}}, {8{be[0]}}};
   endfunction

   function automatic logic [15:0] ref_rd(input logic [15:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
   endfunction

   task automatic ref_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
      ref_mem[a] = (ref_rd(a) & ~lane_mask(be)) | (d & lane_mask(be));
   endtask

   // Memory responder: random ack delay, configurable read latency.
   logic ack_en = 1'b1;
   int   rd_lat = 5;
   int   rv_cnt = 0;
   logic rv_pend = 1'b0;

   initial begin
      req_t g, e;
      int   n;
      logic [15:0] old;
      mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'h0;
      forever begin
         @(posedge clk); #1;
         if (mem_req && ack_en) begin
            g = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, be: mem_be};
            n = $urandom_range(0, 2);
            repeat (n) begin @(posedge clk); #1; end
            chk("req_stable", {mem_we, mem_addr, mem_be}, {g.we, g.addr, g.be});
            mem_ack = 1'b1;
            if (exp_q.size() == 0) chk("req_unexpected", {g.we, g.addr}, 17'h0);
            else begin
               e = exp_q.pop_front();
               chk("req_we", g.we, e.we);
               chk("req_addr", g.addr, e.addr);
               chk("req_be", g.be, e.be);
               if (e.we) chk("req_wdata", g.wdata, e.wdata);
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (g.we) begin
               old = env_mem.exists(g.addr) ? env_mem[g.addr] : 16'h0;
               env_mem[g.addr] = (old & ~lane_mask(g.be)) | (g.wdata & lane_mask(g.be));
            end else begin
               rv_pend = 1'b1;
               repeat (rd_lat - 1) begin @(posedge clk); #1; end
               mem_rvalid = 1'b1;
               mem_rdata  = env_mem.exists(g.addr) ? env_mem[g.addr] : 16'h0;
               @(posedge clk); #1;
               mem_rvalid = 1'b0;
               mem_rdata  = 16'h0;
               rv_pend    = 1'b0;
               rv_cnt++;
            end
         end
      end
   end

   logic [1:0] lat_be;

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic fsmc_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] nbl,
                             input int hold, input bit post, input bit chk_lat);
      @(posedge clk); #1;
      fsmc_a = a; tb_d = d; tb_d_oe = 1'b1; {nbl1, nbl0} = nbl; ne1 = 1'b0; nwe = 1'b0;
      cyc(hold);
      ne1 = 1'b1; nwe = 1'b1;
      if (post) begin
         exp_q.push_back('{we: 1'b1, addr: a, wdata: d, be: ~nbl});
         ref_write(a, d, ~nbl);
      end
      for (int i = 1; i <= 4; i++) begin
         cyc(1);
         if (chk_lat && i <= 3) chk("wr_latency", mem_req, (i == 3));
         if (i == 3) lat_be = mem_be;
      end
      fsmc_a = 16'($urandom); tb_d = 16'($urandom); {nbl1, nbl0} = 2'($urandom); tb_d_oe = 1'b0;
      cyc(2);
   endtask

   task automatic fsmc_read(input logic [15:0] a, input logic [1:0] nbl, input int post, input bit chk_lat);
      logic [15:0] exp_d;
      int k;
      exp_d = ref_rd(a);
      exp_q.push_back('{we: 1'b0, addr: a, wdata: 16'h0, be: ~nbl});
      @(posedge clk); #1;
      fsmc_a = a; {nbl1, nbl0} = nbl; tb_d_oe = 1'b0; ne1 = 1'b0; noe = 1'b0;
      if (chk_lat)
         for (int i = 1; i <= 3; i++) begin cyc(1); chk("rd_latency", mem_req, (i == 3)); end
      k = 0;
      while (!d_oe && k < 400) begin cyc(1); k++; end
      if (!d_oe) chk("rd_oe_timeout", d_oe, 1'b1);
      else begin
         chk("rd_data", fsmc_d, exp_d);
         cyc(post);
         chk("rd_data_hold", {d_oe, fsmc_d}, {1'b1, exp_d});
      end
      ne1 = 1'b1; noe = 1'b1;
      for (int i = 1; i <= 3; i++) begin cyc(1); chk("oe_fall", d_oe, (i < 3)); end
      cyc(3);
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while ((busy || exp_q.size() != 0) && k < 500) begin cyc(1); k++; end
      chk(tag, {busy, 8'(exp_q.size())}, 9'h0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; ne1 = 1'b1; nwe = 1'b1; noe = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(2);
   endtask

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog checks=%0d", checks);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int k;
      logic seen;
      rst = 1'b1; ne1 = 1'b1; nwe = 1'b1; noe = 1'b1; nbl1 = 1'b1; nbl0 = 1'b1;
      fsmc_a = 16'h0; tb_d = 16'h0; tb_d_oe = 1'b0;
      cyc(3);
      chk("rst_outputs", {mem_req, mem_we, busy, err_ovf, d_oe, mem_be}, 7'h0);
      chk("rst_addr_data", {mem_addr, mem_wdata}, 32'h0);
      rst = 1'b0;
      cyc(3);

      // Single long write
      fsmc_write(16'hAAAA, 16'hBBBB, 2'b00, 50, 1'b1, 1'b1);
      chk("single_be", lat_be, 2'b11);
      wait_idle("single_idle");

      // Write then read back
      rd_lat = 5;
      fsmc_write(16'hCCCC, 16'hDDDD, 2'b00, 6, 1'b1, 1'b1);
      wait_idle("wr_idle");
      fsmc_read(16'hCCCC, 2'b00, 4, 1'b1);
      wait_idle("rd_idle");

      // Byte lanes
      fsmc_write(16'h0010, 16'h1234, 2'b10, 5, 1'b1, 1'b1);
      chk("be_lane0", lat_be, 2'b01);
      fsmc_write(16'h0011, 16'h5678, 2'b11, 5, 1'b1, 1'b1);
      chk("be_none", lat_be, 2'b00);
      wait_idle("be_idle");

      // Read start while a write is still unacked: read must follow the write
      ack_en = 1'b0;
      fsmc_write(16'h0020, 16'h9ABC, 2'b00, 5, 1'b1, 1'b0);
      fork
         fsmc_read(16'h0020, 2'b00, 2, 1'b0);
         begin cyc(20); ack_en = 1'b1; end
      join
      wait_idle("pend_idle");

      // Overflow: second write completes while first unacked
      ack_en = 1'b0;
      fsmc_write(16'h0031, 16'h1111, 2'b00, 5, 1'b1, 1'b0);
      fsmc_write(16'h0032, 16'h2222, 2'b00, 5, 1'b0, 1'b0);
      chk("ovf_flag", err_ovf, 1'b1);
      chk("ovf_kept_addr", {mem_req, mem_addr}, {1'b1, 16'h0031});
      ack_en = 1'b1;
      wait_idle("ovf_idle");
      chk("ovf_sticky", err_ovf, 1'b1);
      do_reset();
      chk("ovf_cleared", err_ovf, 1'b0);

      // Aborted read: strobe released long before data returns
      rd_lat = 100;
      exp_q.push_back('{we: 1'b0, addr: 16'h0040, wdata: 16'h0, be: 2'b11});
      @(posedge clk); #1;
      fsmc_a = 16'h0040; {nbl1, nbl0} = 2'b00; ne1 = 1'b0; noe = 1'b0;
      cyc(8);
      ne1 = 1'b1; noe = 1'b1;
      k = rv_cnt; seen = 1'b0;
      for (int i = 0; i < 200 && rv_cnt == k; i++) begin cyc(1); seen |= d_oe; end
      cyc(2);
      chk("abort_rvalid", rv_cnt, k + 1);
      chk("abort_no_oe", seen | d_oe, 1'b0);
      chk("abort_idle", busy, 1'b0);

      // Reset in RD_DRIVE
      rd_lat = 5;
      exp_q.push_back('{we: 1'b0, addr: 16'hCCCC, wdata: 16'h0, be: 2'b11});
      @(posedge clk); #1;
      fsmc_a = 16'hCCCC; {nbl1, nbl0} = 2'b00; ne1 = 1'b0; noe = 1'b0;
      k = 0;
      while (!d_oe && k < 100) begin cyc(1); k++; end
      chk("rstdrv_oe_before", d_oe, 1'b1);
      rst = 1'b1; ne1 = 1'b1; noe = 1'b1;
      #1;
      chk("rstdrv_outputs", {mem_req, mem_we, busy, err_ovf, d_oe, mem_be}, 7'h0);
      chk("rstdrv_addr", {mem_addr, mem_wdata}, 32'h0);
      cyc(2);
      rst = 1'b0;
      cyc(3);

      // Reset in RD_WAIT: late rvalid must be ignored
      rd_lat = 30;
      exp_q.push_back('{we: 1'b0, addr: 16'hCCCC, wdata: 16'h0, be: 2'b11});
      @(posedge clk); #1;
      fsmc_a = 16'hCCCC; ne1 = 1'b0; noe = 1'b0;
      k = 0;
      while (!rv_pend && k < 100) begin cyc(1); k++; end
      chk("rstwait_pending", rv_pend, 1'b1);
      do_reset();
      k = rv_cnt; seen = 1'b0;
      for (int i = 0; i < 100 && rv_cnt == k; i++) begin cyc(1); seen |= d_oe | busy | mem_req; end
      cyc(3);
      chk("rstwait_ignored", {seen, d_oe, busy, mem_req}, 4'h0);

      // Randomized mix of writes and reads over a small address window
      for (int it = 0; it < 40; it++) begin
         logic [15:0] a;
         a = 16'h0100 + 16'($urandom_range(0, 7));
         rd_lat = $urandom_range(1, 8);
         if ($urandom_range(0, 2) != 0)
            fsmc_write(a, 16'($urandom), 2'($urandom), $urandom_range(4, 8), 1'b1, 1'b1);
         else
            fsmc_read(a, 2'($urandom), $urandom_range(0, 3), 1'b1);
         wait_idle("rand_idle");
      end

      chk("final_no_err", err_ovf, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
